// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - ALU result capture FIFO with sequence tagging, drop-on-full and sticky overflow
module alu_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2*DATA_WIDTH-1:0]          ex_alu,
  input  logic                             ex_alu_vld,
  output logic                             alu_rdy,
  output logic [2*DATA_WIDTH-1:0]          out_data,
  output logic [7:0]                       out_seq,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             overflow,
  input  logic                             ovf_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_RDY_MAX = CW'(FIFO_DEPTH - 2);

  logic [2*DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [7:0]              mem_seq  [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [7:0]              seq;
  logic [CW-1:0]           cnt_next;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    drop;

  assign out_vld  = (cnt != '0);
  assign full     = (cnt == CNT_FULL);
  assign pop      = out_vld & out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = ex_alu_vld & (~full | pop);
  assign drop     = ex_alu_vld & full & ~pop;
  assign out_data = mem_data[rd_ptr];
  assign out_seq  = mem_seq[rd_ptr];

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)
      cnt_next = cnt + CW'(1);
    else if (pop && !push)
      cnt_next = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= 8'd0;
      overflow <= 1'b0;
      alu_rdy  <= 1'b1;
    end else begin
      cnt     <= cnt_next;
      // Keep one entry spare for the result already in flight in the ALU.
      alu_rdy <= (cnt_next <= CNT_RDY_MAX);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (ex_alu_vld)
        seq <= seq + 8'd1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= ex_alu;
      mem_seq[wr_ptr]  <= seq;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - self-checking bench for alu_result_fifo: vector table, corner sequences, random vs queue model
module tb_alu_result_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   ex_alu;
  logic          ex_alu_vld;
  logic          alu_rdy;
  logic [15:0]   out_data;
  logic [7:0]    out_seq;
  logic          out_vld;
  logic          out_rdy;
  logic          overflow;
  logic          ovf_clr;
  logic [2:0]    cnt;

  int checks = 0;
  int errors = 0;

  alu_result_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_alu(ex_alu), .ex_alu_vld(ex_alu_vld),
    .alu_rdy(alu_rdy), .out_data(out_data), .out_seq(out_seq), .out_vld(out_vld),
    .out_rdy(out_rdy), .overflow(overflow), .ovf_clr(ovf_clr), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  s;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mseq;
  bit         movf;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [15:0] d;
    bit          rdy;
    bit          clr;
    bit          e_vld;
    logic [15:0] e_d;
    logic [7:0]  e_s;
    int          e_cnt;
    bit          e_ovf;
    bit          e_ardy;
  } tv_t;

  tv_t tv[$];

  function automatic tv_t mk(bit rst, bit vld, logic [15:0] d, bit rdy, bit clr,
                             bit e_vld, logic [15:0] e_d, logic [7:0] e_s,
                             int e_cnt, bit e_ovf, bit e_ardy);
    tv_t t;
    t.rst = rst; t.vld = vld; t.d = d; t.rdy = rdy; t.clr = clr;
    t.e_vld = e_vld; t.e_d = e_d; t.e_s = e_s; t.e_cnt = e_cnt;
    t.e_ovf = e_ovf; t.e_ardy = e_ardy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the queue model, then land 1 time unit after the edge.
  task automatic cycle(input bit vld, input logic [15:0] d, input bit rdy, input bit clr);
    bit   pop;
    bit   full;
    ent_t e;
    ex_alu_vld = vld; ex_alu = d; out_rdy = rdy; ovf_clr = clr;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) e = mq.pop_front();
    if (vld && full && !pop) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (vld) begin
      if (!full || pop) begin
        e.d = d; e.s = mseq;
        mq.push_back(e);
      end
      mseq = mseq + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    mseq = 8'd0;
    movf = 1'b0;
  endtask

  task automatic do_reset();
    ex_alu_vld = 1'b0; out_rdy = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".vld"}, 32'(out_vld), 32'(mq.size() != 0));
    chk({tag, ".cnt"}, 32'(cnt), 32'(mq.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
    chk({tag, ".ardy"}, 32'(alu_rdy), 32'((DEPTH - mq.size()) >= 2));
    if (mq.size() != 0) begin
      chk({tag, ".data"}, 32'(out_data), 32'(mq[0].d));
      chk({tag, ".seq"}, 32'(out_seq), 32'(mq[0].s));
    end
  endtask

  initial begin
    logic [15:0] last_d;
    logic [7:0]  prev_seq;
    bit          saw_wrap;
    bit          any_drop;

    rst_n = 1'b0; ex_alu = '0; ex_alu_vld = 1'b0; out_rdy = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset.vld", 32'(out_vld), 0);
    chk("reset.cnt", 32'(cnt), 0);
    chk("reset.ovf", 32'(overflow), 0);
    chk("reset.ardy", 32'(alu_rdy), 1);
    rst_n = 1'b1;

    // rst vld data rdy clr | vld data seq cnt ovf ardy
    tv.push_back(mk(1, 1, 16'h00A5, 1, 0, 1, 16'h00A5, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 1));
    tv.push_back(mk(1, 1, 16'h0001, 0, 0, 1, 16'h0001, 0, 1, 0, 1));
    tv.push_back(mk(0, 1, 16'h0002, 0, 0, 1, 16'h0001, 0, 2, 0, 1));
    tv.push_back(mk(0, 1, 16'h0003, 0, 0, 1, 16'h0001, 0, 3, 0, 0));
    tv.push_back(mk(0, 1, 16'h0004, 0, 0, 1, 16'h0001, 0, 4, 0, 0));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0002, 1, 3, 0, 0));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0003, 2, 2, 0, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0004, 3, 1, 0, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 1));
    tv.push_back(mk(1, 1, 16'h0001, 0, 0, 1, 16'h0001, 0, 1, 0, 1));
    tv.push_back(mk(0, 1, 16'h0002, 0, 0, 1, 16'h0001, 0, 2, 0, 1));
    tv.push_back(mk(0, 1, 16'h0003, 0, 0, 1, 16'h0001, 0, 3, 0, 0));
    tv.push_back(mk(0, 1, 16'h0004, 0, 0, 1, 16'h0001, 0, 4, 0, 0));
    tv.push_back(mk(0, 1, 16'h0005, 0, 0, 1, 16'h0001, 0, 4, 1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0002, 1, 3, 1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0003, 2, 2, 1, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0004, 3, 1, 1, 1));
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 16'h0006, 0, 0, 1, 16'h0006, 5, 1, 1, 1));

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      cycle(tv[i].vld, tv[i].d, tv[i].rdy, tv[i].clr);
      chk($sformatf("tv%0d.vld", i), 32'(out_vld), 32'(tv[i].e_vld));
      chk($sformatf("tv%0d.cnt", i), 32'(cnt), 32'(tv[i].e_cnt));
      chk($sformatf("tv%0d.ovf", i), 32'(overflow), 32'(tv[i].e_ovf));
      chk($sformatf("tv%0d.ardy", i), 32'(alu_rdy), 32'(tv[i].e_ardy));
      if (tv[i].e_vld) begin
        chk($sformatf("tv%0d.data", i), 32'(out_data), 32'(tv[i].e_d));
        chk($sformatf("tv%0d.seq", i), 32'(out_seq), 32'(tv[i].e_s));
      end
    end

    // Clear together with a drop: the drop wins.
    for (int i = 0; i < 3; i++) cycle(1, 16'h0010 + 16'(i), 0, 0);
    chk("ovfclr.full", 32'(cnt), 4);
    cycle(1, 16'h0020, 0, 1);
    chk("ovfclr.drop_wins", 32'(overflow), 1);
    check_model("ovfclr.drop");
    cycle(0, 16'h0000, 0, 1);
    chk("ovfclr.cleared", 32'(overflow), 0);
    check_model("ovfclr.clear");

    // Full FIFO with simultaneous push and pop.
    cycle(1, 16'h00AA, 1, 0);
    chk("fullpp.cnt", 32'(cnt), 4);
    chk("fullpp.ovf", 32'(overflow), 0);
    check_model("fullpp");
    last_d = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      if (out_vld) last_d = out_data;
      cycle(0, 16'h0000, 1, 0);
      check_model("fullpp.drain");
    end
    chk("fullpp.last", 32'(last_d), 32'(16'h00AA));

    // Sequence wrap over 300 back-to-back results.
    do_reset();
    saw_wrap = 1'b0;
    any_drop = 1'b0;
    prev_seq = 8'd0;
    for (int i = 0; i < 300; i++) begin
      cycle(1, 16'($urandom), 1, 0);
      if (i > 0 && prev_seq == 8'd255 && out_seq == 8'd0) saw_wrap = 1'b1;
      if (i > 0 && out_seq != prev_seq + 8'd1) any_drop = 1'b1;
      prev_seq = out_seq;
      check_model("wrap");
    end
    chk("wrap.seen", 32'(saw_wrap), 1);
    chk("wrap.nogap", 32'(any_drop), 0);
    chk("wrap.noovf", 32'(overflow), 0);

    // Asynchronous reset between edges with three entries and OVERFLOW set.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 16'h0030 + 16'(i), 0, 0);
    cycle(0, 16'h0000, 1, 0);
    chk("areset.pre_cnt", 32'(cnt), 3);
    chk("areset.pre_ovf", 32'(overflow), 1);
    ex_alu_vld = 1'b0; out_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.vld", 32'(out_vld), 0);
    chk("areset.cnt", 32'(cnt), 0);
    chk("areset.ardy", 32'(alu_rdy), 1);
    chk("areset.ovf", 32'(overflow), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle(1, 16'h0BEE, 0, 0);
    chk("areset.seq0", 32'(out_seq), 0);
    chk("areset.data", 32'(out_data), 32'(16'h0BEE));

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Output-side responder for the ALU result interface. Every valid ALU result (EX_ALU/EX_ALU_VLD) is captured into a small FIFO and tagged with an 8-bit sequence number. The results are then forwarded to the consumer over a valid/ready handshake. ALU_RDY throttles the ALU, and a sticky OVERFLOW flag records dropped results; results are always dropped, never stalled. The block sits between the ALU's EX stage and the result checker/bus.

## Interface
- DATA_WIDTH, 8, ALU operand width; the result bus is 2*DATA_WIDTH wide.
- FIFO_DEPTH, 4, number of entries; must be a power of two and ≥ 2.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EX_ALU  in  2*DATA_WIDTH  ALU result.
- EX_ALU_VLD  in  1  EX_ALU valid this cycle; no handshake, so one result per asserted cycle.
- ALU_RDY  out  1  registered; high when the ALU may issue a new operation.
- OUT_DATA  out  2*DATA_WIDTH  head-entry result.
- OUT_SEQ  out  8  head-entry sequence number.
- OUT_VLD  out  1  head entry valid.
- OUT_RDY  in  1  consumer accepts the head entry.
- OVERFLOW  out  1  sticky; set when a result was dropped.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.
- CNT  out  $clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
- Push: EX_ALU_VLD=1 and (not full, or pop in the same cycle). Writes {EX_ALU, seq} at the write pointer.
- Pop: OUT_VLD=1 and OUT_RDY=1. Advances the read pointer.
- Full with simultaneous push and pop: both are performed and occupancy is unchanged.
- Empty with EX_ALU_VLD=1 and OUT_RDY=1: the push happens; no pop, since OUT_VLD=0 that cycle (no bypass).
- Drop: EX_ALU_VLD=1, full, and no pop. The result is discarded, OVERFLOW is set, and CNT is unchanged.
- Sequence counter seq (8 bit, reset 0):
  - increments on every EX_ALU_VLD cycle, accepted or dropped, so the consumer sees gaps on drops;
  - wraps 255 → 0.
- OVERFLOW: set by a drop, cleared by OVF_CLR. Set wins if both occur in the same cycle.
- Pointers: log2(FIFO_DEPTH) bits and wrap naturally. CNT is a separate counter from 0 to FIFO_DEPTH.
- OUT_VLD = (CNT ≠ 0). OUT_DATA/OUT_SEQ come from the head entry.
  - While OUT_VLD=1 and OUT_RDY=0, they hold stable.
  - While OUT_VLD=0, their value is don't-care.
- ALU_RDY next-state: (FIFO_DEPTH − CNT_next) ≥ 2. This leaves one entry of slack for the in-flight ALU result.

## Timing
- Reset (RST_N=0, asynchronous): CNT=0, pointers=0, seq=0, OUT_VLD=0, OVERFLOW=0, ALU_RDY=1.
  - OUT_DATA/OUT_SEQ storage is not reset.
  - Reset mid-operation discards all entries immediately.
- Latency: a push at edge k gives OUT_VLD=1 with that data after edge k, i.e. 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- ALU_RDY reflects occupancy after edge k, visible in cycle k+1. It deasserts when CNT reaches FIFO_DEPTH−1.
- OVERFLOW and CNT update at the same edge as the push or drop.

## Test plan
- Single result: reset, then EX_ALU=16'h00A5 with EX_ALU_VLD=1 for one cycle, OUT_RDY=1. Expect:
  - OUT_VLD high for exactly 1 cycle, starting the cycle after the push;
  - OUT_DATA=16'h00A5, OUT_SEQ=0.
- Fill and backpressure: OUT_RDY=0, push 4 results 1..4. Expect:
  - CNT=4;
  - ALU_RDY low from CNT=3 onward;
  - OUT_DATA stays at 1.
  
  Then OUT_RDY=1: outputs 1,2,3,4 in consecutive cycles with seq 0..3, after which ALU_RDY=1 and OUT_VLD=0.
- Overflow: FIFO full, OUT_RDY=0, push value 5. Expect:
  - OVERFLOW=1, CNT=4.
  
  Then push 6 after draining. Expect OUT_SEQ=5, showing the gap at seq 4. Finally assert OVF_CLR together with another drop: OVERFLOW stays 1.
- Full push and pop: FIFO full, EX_ALU_VLD=1 and OUT_RDY=1 together. Expect:
  - CNT stays 4, no OVERFLOW;
  - the new entry appears last in order.
- Sequence wrap: 300 pushes with OUT_RDY=1. Expect OUT_SEQ going 254, 255, 0, 1 and no drops.
- Async reset mid-stream: RST_N low between edges with CNT=3. Expect, immediately and without waiting for an edge:
  - OUT_VLD=0, CNT=0, ALU_RDY=1, OVERFLOW=0;
  - the first push after release carries seq 0.
